// File: rtl/magia_axi_putchar.sv
// Console character to AXI4 single-beat write bridge for the L2 print addresses.
// Keeps exactly one print write outstanding so the print monitor can pair AW and W without ambiguity.
module magia_axi_putchar #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ID_W        = 2,
    parameter int unsigned       AXI_ID      = 0,
    parameter logic [ADDR_W-1:0] STDOUT_ADDR = ADDR_W'(32'hFFFF_0004),
    parameter logic [ADDR_W-1:0] STDERR_ADDR = ADDR_W'(32'hFFFF_0000)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // character source
    input  logic                  char_valid_i,
    output logic                  char_ready_o,
    input  logic [7:0]            char_data_i,
    input  logic                  char_err_i,
    // AW channel
    output logic                  aw_valid_o,
    input  logic                  aw_ready_i,
    output logic [ADDR_W-1:0]     aw_addr_o,
    output logic [ID_W-1:0]       aw_id_o,
    output logic [7:0]            aw_len_o,
    output logic [2:0]            aw_size_o,
    output logic [1:0]            aw_burst_o,
    // W channel
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    output logic [DATA_W-1:0]     w_data_o,
    output logic [DATA_W/8-1:0]   w_strb_o,
    output logic                  w_last_o,
    // B channel
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [1:0]            b_resp_i,
    // status
    output logic                  busy_o,
    output logic [31:0]           sent_cnt_o,
    output logic [15:0]           drop_cnt_o,
    output logic [15:0]           err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned STRB_W = DATA_W / 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

    // Only the low four byte lanes carry the character word, whatever the bus width.
    function automatic logic [STRB_W-1:0] low_word_strb();
        logic [STRB_W-1:0] strb;
        strb = '0;
        for (int i = 0; i < 4; i++) begin
            strb[i] = 1'b1;
        end
        return strb;
    endfunction

    state_e            state_r, state_s;
    logic              aw_pend_r, aw_pend_s;
    logic              w_pend_r, w_pend_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [7:0]        data_r, data_s;
    logic [31:0]       sent_cnt_r, sent_cnt_s;
    logic [15:0]       drop_cnt_r, drop_cnt_s;
    logic [15:0]       err_cnt_r, err_cnt_s;
    logic              char_ready_r;
    logic              b_ready_r;
    logic              busy_r;

    // Next-state, channel bookkeeping and counter updates.
    always_comb begin
        state_s    = state_r;
        aw_pend_s  = aw_pend_r;
        w_pend_s   = w_pend_r;
        addr_s     = addr_r;
        data_s     = data_r;
        sent_cnt_s = sent_cnt_r;
        drop_cnt_s = drop_cnt_r;
        err_cnt_s  = err_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (char_valid_i) begin
                    // A zero byte is meaningless to the print monitor, so it never reaches the bus.
                    if (char_data_i == 8'd0) begin
                        drop_cnt_s = sat_inc16(drop_cnt_r);
                        state_s    = ST_IDLE;
                    end else begin
                        addr_s    = char_err_i ? STDERR_ADDR : STDOUT_ADDR;
                        data_s    = char_data_i;
                        aw_pend_s = 1'b1;
                        w_pend_s  = 1'b1;
                        state_s   = ST_SEND;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                aw_pend_s = aw_pend_r & ~aw_ready_i;
                w_pend_s  = w_pend_r & ~w_ready_i;
                if (!aw_pend_s && !w_pend_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_RESP: begin
                if (b_valid_i) begin
                    if (b_resp_i == 2'b00) begin
                        sent_cnt_s = sent_cnt_r + 32'd1;
                    end else begin
                        err_cnt_s = sat_inc16(err_cnt_r);
                    end
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                aw_pend_s = 1'b0;
                w_pend_s  = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State, payload and counter registers; reset aborts any write in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            aw_pend_r  <= 1'b0;
            w_pend_r   <= 1'b0;
            addr_r     <= '0;
            data_r     <= 8'd0;
            sent_cnt_r <= 32'd0;
            drop_cnt_r <= 16'd0;
            err_cnt_r  <= 16'd0;
        end else begin
            state_r    <= state_s;
            aw_pend_r  <= aw_pend_s;
            w_pend_r   <= w_pend_s;
            addr_r     <= addr_s;
            data_r     <= data_s;
            sent_cnt_r <= sent_cnt_s;
            drop_cnt_r <= drop_cnt_s;
            err_cnt_r  <= err_cnt_s;
        end
    end

    // Handshake and status flags registered from the next state so they are glitch-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            char_ready_r <= 1'b1;
            b_ready_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            char_ready_r <= (state_s == ST_IDLE);
            b_ready_r    <= (state_s == ST_RESP);
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    assign char_ready_o = char_ready_r;
    assign b_ready_o    = b_ready_r;
    assign busy_o       = busy_r;

    assign aw_valid_o   = aw_pend_r;
    assign aw_addr_o    = addr_r;
    assign aw_id_o      = ID_W'(AXI_ID);
    assign aw_len_o     = 8'd0;
    assign aw_size_o    = 3'd2;
    assign aw_burst_o   = 2'b01;

    assign w_valid_o    = w_pend_r;
    assign w_data_o     = DATA_W'(data_r);
    assign w_strb_o     = low_word_strb();
    assign w_last_o     = 1'b1;

    assign sent_cnt_o   = sent_cnt_r;
    assign drop_cnt_o   = drop_cnt_r;
    assign err_cnt_o    = err_cnt_r;

endmodule

// File: tb/tb_magia_axi_putchar.sv
// Directed bench for magia_axi_putchar: each step drives inputs just after a rising edge
// and checks the registered outputs before the next one.
module tb_magia_axi_putchar;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        char_valid_i;
    logic        char_ready_o;
    logic [7:0]  char_data_i;
    logic        char_err_i;
    logic        aw_valid_o;
    logic        aw_ready_i;
    logic [31:0] aw_addr_o;
    logic [1:0]  aw_id_o;
    logic [7:0]  aw_len_o;
    logic [2:0]  aw_size_o;
    logic [1:0]  aw_burst_o;
    logic        w_valid_o;
    logic        w_ready_i;
    logic [31:0] w_data_o;
    logic [3:0]  w_strb_o;
    logic        w_last_o;
    logic        b_valid_i;
    logic        b_ready_o;
    logic [1:0]  b_resp_i;
    logic        busy_o;
    logic [31:0] sent_cnt_o;
    logic [15:0] drop_cnt_o;
    logic [15:0] err_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int aw_hs    = 0;
    int w_hs     = 0;

    magia_axi_putchar dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .char_valid_i (char_valid_i),
        .char_ready_o (char_ready_o),
        .char_data_i  (char_data_i),
        .char_err_i   (char_err_i),
        .aw_valid_o   (aw_valid_o),
        .aw_ready_i   (aw_ready_i),
        .aw_addr_o    (aw_addr_o),
        .aw_id_o      (aw_id_o),
        .aw_len_o     (aw_len_o),
        .aw_size_o    (aw_size_o),
        .aw_burst_o   (aw_burst_o),
        .w_valid_o    (w_valid_o),
        .w_ready_i    (w_ready_i),
        .w_data_o     (w_data_o),
        .w_strb_o     (w_strb_o),
        .w_last_o     (w_last_o),
        .b_valid_i    (b_valid_i),
        .b_ready_o    (b_ready_o),
        .b_resp_i     (b_resp_i),
        .busy_o       (busy_o),
        .sent_cnt_o   (sent_cnt_o),
        .drop_cnt_o   (drop_cnt_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Count channel handshakes seen on the bus.
    always @(posedge clk_i) begin
        if (!rst_i && aw_valid_o && aw_ready_i) aw_hs <= aw_hs + 1;
        if (!rst_i && w_valid_o && w_ready_i)   w_hs  <= w_hs + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    logic [7:0] hi_str [3];
    int aw_base;
    int w_base;

    initial begin
        hi_str[0] = 8'h48;
        hi_str[1] = 8'h69;
        hi_str[2] = 8'h0A;

        rst_i = 1'b1; char_valid_i = 1'b0; char_data_i = 8'h00; char_err_i = 1'b0;
        aw_ready_i = 1'b1; w_ready_i = 1'b1; b_valid_i = 1'b0; b_resp_i = 2'b00;
        tick(); tick();
        rst_i = 1'b0;
        tick();

        // reset state
        chk("rst_char_ready", char_ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_aw_valid", aw_valid_o, 1'b0);
        chk("rst_w_valid", w_valid_o, 1'b0);
        chk("rst_b_ready", b_ready_o, 1'b0);
        chk("rst_aw_addr", aw_addr_o, 32'h0);
        chk("rst_w_data", w_data_o, 32'h0);
        chk("rst_cnts", {sent_cnt_o, drop_cnt_o, err_cnt_o}, 64'h0);

        // 'H' to stdout; B held valid early to show it is ignored outside RESP
        char_valid_i = 1'b1; char_data_i = 8'h48; char_err_i = 1'b0; b_valid_i = 1'b1;
        tick();
        char_valid_i = 1'b0;
        chk("h_aw_valid", aw_valid_o, 1'b1);
        chk("h_aw_addr", aw_addr_o, 32'hFFFF_0004);
        chk("h_aw_fixed", {aw_id_o, aw_len_o, aw_size_o, aw_burst_o}, {2'd0, 8'd0, 3'd2, 2'b01});
        chk("h_w_valid", w_valid_o, 1'b1);
        chk("h_w_data", w_data_o, 32'h0000_0048);
        chk("h_w_strb_last", {w_strb_o, w_last_o}, 5'b11111);
        chk("h_b_ready_send", b_ready_o, 1'b0);
        chk("h_char_ready_send", char_ready_o, 1'b0);
        chk("h_busy", busy_o, 1'b1);
        tick();
        chk("h_resp_b_ready", b_ready_o, 1'b1);
        chk("h_resp_valids", {aw_valid_o, w_valid_o}, 2'b00);
        chk("h_sent_before_b", sent_cnt_o, 32'd0);
        tick();
        b_valid_i = 1'b0;
        chk("h_idle_char_ready", char_ready_o, 1'b1);
        chk("h_sent", sent_cnt_o, 32'd1);
        chk("h_busy_done", busy_o, 1'b0);

        // error code 0x03 to stderr
        char_valid_i = 1'b1; char_data_i = 8'h03; char_err_i = 1'b1;
        tick();
        char_valid_i = 1'b0; char_err_i = 1'b0;
        chk("e_aw_addr", aw_addr_o, 32'hFFFF_0000);
        chk("e_w_data", w_data_o, 32'h0000_0003);
        tick();
        b_valid_i = 1'b1;
        tick();
        b_valid_i = 1'b0;
        chk("e_sent_err", {sent_cnt_o, err_cnt_o}, {32'd2, 16'd0});

        // W stalled for 4 cycles while AW is accepted at once
        aw_base = aw_hs; w_base = w_hs;
        char_valid_i = 1'b1; char_data_i = 8'h41; w_ready_i = 1'b0;
        tick();
        char_valid_i = 1'b0; b_valid_i = 1'b1;
        chk("ws_c1_valids", {aw_valid_o, w_valid_o}, 2'b11);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("ws_aw_done", aw_valid_o, 1'b0);
            chk("ws_w_held", {w_valid_o, w_data_o}, {1'b1, 32'h0000_0041});
            chk("ws_no_b_ready", b_ready_o, 1'b0);
        end
        tick();
        w_ready_i = 1'b1;
        chk("ws_c5_w_held", w_valid_o, 1'b1);
        tick();
        chk("ws_resp", {b_ready_o, w_valid_o}, 2'b10);
        chk("ws_sent_pending", sent_cnt_o, 32'd2);
        tick();
        b_valid_i = 1'b0;
        chk("ws_sent", sent_cnt_o, 32'd3);
        chk("ws_hs", {aw_hs - aw_base, w_hs - w_base}, {32'd1, 32'd1});

        // AW stalled for 3 cycles while W completes at once; B delayed one extra cycle
        aw_base = aw_hs; w_base = w_hs;
        char_valid_i = 1'b1; char_data_i = 8'h42; aw_ready_i = 1'b0;
        tick();
        char_valid_i = 1'b0;
        chk("as_c1_valids", {aw_valid_o, w_valid_o}, 2'b11);
        tick();
        chk("as_c2", {aw_valid_o, w_valid_o, b_ready_o}, 3'b100);
        chk("as_c2_addr", aw_addr_o, 32'hFFFF_0004);
        tick();
        aw_ready_i = 1'b1;
        chk("as_c3", {aw_valid_o, w_valid_o, b_ready_o}, 3'b100);
        tick();
        chk("as_resp_wait", {b_ready_o, busy_o, aw_valid_o}, 3'b110);
        b_valid_i = 1'b1;
        tick();
        b_valid_i = 1'b0;
        chk("as_sent", sent_cnt_o, 32'd4);
        chk("as_hs", {aw_hs - aw_base, w_hs - w_base}, {32'd1, 32'd1});

        // zero byte is dropped without bus activity
        aw_base = aw_hs; w_base = w_hs;
        char_valid_i = 1'b1; char_data_i = 8'h00;
        tick();
        char_valid_i = 1'b0;
        chk("z_drop", drop_cnt_o, 16'd1);
        chk("z_idle", {char_ready_o, busy_o, aw_valid_o, w_valid_o}, 4'b1000);
        tick();
        chk("z_no_hs", {aw_hs - aw_base, w_hs - w_base}, 64'd0);

        // SLVERR response
        char_valid_i = 1'b1; char_data_i = 8'h45;
        tick();
        char_valid_i = 1'b0;
        tick();
        b_valid_i = 1'b1; b_resp_i = 2'b10;
        tick();
        b_valid_i = 1'b0; b_resp_i = 2'b00;
        chk("slverr_cnts", {sent_cnt_o, err_cnt_o}, {32'd4, 16'd1});

        // reset during SEND aborts asynchronously
        char_valid_i = 1'b1; char_data_i = 8'h46; aw_ready_i = 1'b0; w_ready_i = 1'b0;
        tick();
        char_valid_i = 1'b0;
        chk("rs_in_send", {aw_valid_o, w_valid_o}, 2'b11);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rs_async", {aw_valid_o, w_valid_o, busy_o}, 3'b000);
        tick();
        rst_i = 1'b0; aw_ready_i = 1'b1; w_ready_i = 1'b1;
        tick();
        chk("rs_idle", {char_ready_o, busy_o, b_ready_o}, 3'b100);
        chk("rs_cnts", {sent_cnt_o, drop_cnt_o, err_cnt_o}, 64'h0);
        chk("rs_addr", aw_addr_o, 32'h0);

        // "Hi\n" back to back: one accept every 3 cycles, idle again at cycle 9
        b_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            char_valid_i = 1'b1; char_data_i = hi_str[i];
            chk("hi_accept", char_ready_o, 1'b1);
            tick();
            chk("hi_w", {w_valid_o, aw_valid_o, w_data_o}, {1'b1, 1'b1, 24'h0, hi_str[i]});
            tick();
            chk("hi_resp", {b_ready_o, char_ready_o}, 2'b10);
            tick();
        end
        char_valid_i = 1'b0; b_valid_i = 1'b0;
        chk("hi_done", {char_ready_o, busy_o}, 2'b10);
        chk("hi_sent", sent_cnt_o, 32'd3);
        tick();
        chk("hi_quiet", {aw_valid_o, w_valid_o, sent_cnt_o}, {2'b00, 32'd3});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/magia_axi_putchar.md
Name: magia_axi_putchar

Overview:
- AXI4 write initiator that turns a byte stream of console characters into single-beat AXI writes to the L2 print addresses: 0xFFFF_0004 for stdout, 0xFFFF_0000 for stderr / error code.
- Sits on the tile's data-out AXI path, driven by a core-side or DMA-side character source.
- Acts as the transmitting end of the testbench print monitor. It guarantees exactly one outstanding print write, so AW/W pairing at the monitor is unambiguous.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (multiple of 8, >= 32).
- ID_W, 2, AXI ID width.
- AXI_ID, 0, constant ID driven on aw_id_o.
- STDOUT_ADDR, 32'hFFFF0004, target address for stdout characters.
- STDERR_ADDR, 32'hFFFF0000, target address for stderr / error code.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- char_valid_i  in  1  character valid
- char_ready_o  out  1  character accepted when valid & ready
- char_data_i  in  8  character / error code
- char_err_i  in  1  1 = stderr address, 0 = stdout address
- aw_valid_o  out  1  AW valid
- aw_ready_i  in  1  AW ready
- aw_addr_o  out  ADDR_W  AW address
- aw_id_o  out  ID_W  AW ID (= AXI_ID)
- aw_len_o  out  8  fixed 0
- aw_size_o  out  3  fixed 3'd2 (4 bytes)
- aw_burst_o  out  2  fixed INCR (2'b01)
- w_valid_o  out  1  W valid
- w_ready_i  in  1  W ready
- w_data_o  out  DATA_W  zero-extended character
- w_strb_o  out  DATA_W/8  lower 4 bits set, rest 0
- w_last_o  out  1  fixed 1
- b_valid_i  in  1  B valid
- b_ready_o  out  1  B ready
- b_resp_i  in  2  B response
- busy_o  out  1  transaction in flight
- sent_cnt_o  out  32  characters completed with OKAY
- drop_cnt_o  out  16  zero characters dropped
- err_cnt_o  out  16  B responses other than OKAY

Behaviour:
- Reset: FSM=IDLE; all valids, b_ready_o and busy_o = 0; counters = 0; aw_addr_o / w_data_o = 0. Reset asserted mid-transaction aborts immediately, with no completion or counter update.
- FSM IDLE:
  - char_ready_o = 1 only in IDLE.
  - On a handshake with char_data_i == 0: the character is dropped, since the receiver ignores zero. drop_cnt_o increments (saturating) and the FSM stays in IDLE.
  - On a handshake with a nonzero character: latch the address (char_err_i ? STDERR_ADDR : STDOUT_ADDR) and the data, set aw_pend = w_pend = 1, and go to SEND.
- FSM SEND:
  - aw_valid_o = aw_pend and w_valid_o = w_pend, both asserted in the first SEND cycle, i.e. the cycle after acceptance.
  - Each of aw_pend / w_pend clears on its own handshake. Channels complete in any order, including the same cycle; W before AW is legal.
  - Payloads stay stable while the corresponding valid is high. A valid never drops without its ready.
  - When both channels are done (including when the last one completes this cycle), go to RESP.
- FSM RESP:
  - b_ready_o = 1.
  - On b_valid_i: if b_resp_i == 0, sent_cnt_o increments (wrapping); otherwise err_cnt_o increments (saturating at 0xFFFF). Then return to IDLE.
  - B IDs are not checked.
- busy_o = (state != IDLE).
- Minimum latency, with ready/B immediate: accept at cycle 0, AW+W at cycle 1, B at cycle 2, IDLE at cycle 3. Throughput is 1 char / 3 cycles.
- A char_valid_i held during a busy period waits; there is no internal FIFO.
- A b_valid_i arriving outside RESP is ignored (b_ready_o = 0).

Test Plan:
- Send 'H' (0x48) with err=0, all readies at 1 -> AW addr 0xFFFF0004 at cycle 1, W data 0x00000048 with strb 0xF, B OKAY, sent_cnt=1, char_ready high again at cycle 3.
- err=1, data 0x03 -> AW addr 0xFFFF0000, W data 0x3, err_cnt unchanged on OKAY.
- w_ready held 0 for 4 cycles while aw_ready=1 -> AW completes at cycle 1; W valid stays high with stable data until ready; B accepted only afterwards.
- aw_ready delayed 3 cycles while W completes at cycle 1 -> exactly one AW; FSM enters RESP only after AW completes; no duplicate W.
- data 0x00 -> no AXI activity, drop_cnt=1, char_ready stays 1.
- B resp SLVERR (2'b10) -> err_cnt=1, sent_cnt unchanged.
- Assert rst_i during SEND -> aw/w valid deasserted asynchronously; after release FSM is IDLE with counters at 0.
- Stream "Hi\n" back-to-back -> 3 serialized writes, 0x48 / 0x69 / 0x0A, 9 cycles total.
